// File: rtl/msdap_serial_rx.sv
// msdap_serial_rx
// Bit-serial receive front end of the MSDAP core. It oversamples the host's
// dClk/frame/inData on sClk and assembles MSB-first 16-bit words. Each word is
// tagged as Rj, coefficient or data according to the load order. A long run of
// zero data words raises a sleep indication.
//
// Output handshake: word_valid is a one-cycle strobe with no back-pressure.
// While it is high, word, word_type and word_index describe one received word.
// The consumer must take the word in that cycle. word holds its value until the
// next strobe. inReady is high whenever the block has left IDLE and is
// sampling serial bits.
module msdap_serial_rx #(
  parameter int RJ_N     = 16,
  parameter int COEFF_N  = 159,
  parameter int ZERO_RUN = 800,
  parameter int IDX_W    = 9
) (
  input  logic             sClk,
  input  logic             reset,
  input  logic             start,
  input  logic             dClk,
  input  logic             frame,
  input  logic             inData,
  output logic             inReady,
  output logic [15:0]      word,
  output logic             word_valid,
  output logic [1:0]       word_type,
  output logic [IDX_W-1:0] word_index,
  output logic             sleep,
  output logic             frame_err
);

  // Load-phase FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RJ    = 2'd1;
  localparam logic [1:0] COEFF = 2'd2;
  localparam logic [1:0] DATA  = 2'd3;

  localparam int ZW = $clog2(ZERO_RUN + 1);
  localparam logic [IDX_W-1:0] RJ_LAST    = IDX_W'(RJ_N - 1);
  localparam logic [IDX_W-1:0] COEFF_LAST = IDX_W'(COEFF_N - 1);
  localparam logic [ZW-1:0]    ZERO_MAX   = ZW'(ZERO_RUN);
  localparam logic [ZW-1:0]    ZERO_PRE   = ZW'(ZERO_RUN - 1);

  logic [1:0]       state;
  logic [3:0]       bitCnt;
  logic [15:0]      shiftReg;
  logic [IDX_W-1:0] classIdx;
  logic [ZW-1:0]    zeroCnt;

  logic dClkS1, dClkS2, dClkHist;
  logic frameS1, frameS2;
  logic dataS1, dataS2;

  logic        sampleEvt;
  logic [15:0] nextWord;
  logic [1:0]  curType;

  // Two-flop synchronizers plus a history flop to detect the dClk fall
  always_ff @(posedge sClk) begin
    if (reset) begin
      dClkS1   <= 1'b0;
      dClkS2   <= 1'b0;
      dClkHist <= 1'b0;
      frameS1  <= 1'b0;
      frameS2  <= 1'b0;
      dataS1   <= 1'b0;
      dataS2   <= 1'b0;
    end else begin
      dClkS1   <= dClk;
      dClkS2   <= dClkS1;
      dClkHist <= dClkS2;
      frameS1  <= frame;
      frameS2  <= frameS1;
      dataS1   <= inData;
      dataS2   <= dataS1;
    end
  end

  // Sample event, the word completed by the current bit, and the class tag
  always_comb begin
    sampleEvt = dClkHist & ~dClkS2;
    nextWord  = {shiftReg[14:0], dataS2};
    curType   = 2'd0;
    case (state)
      COEFF:   curType = 2'd1;
      DATA:    curType = 2'd2;
      default: curType = 2'd0;
    endcase
  end

  assign inReady = (state != IDLE);

  // Load FSM, bit assembly, class indexing and zero-run sleep tracking
  always_ff @(posedge sClk) begin
    if (reset) begin
      state      <= IDLE;
      bitCnt     <= 4'd0;
      shiftReg   <= 16'd0;
      classIdx   <= '0;
      zeroCnt    <= '0;
      word       <= 16'd0;
      word_valid <= 1'b0;
      word_type  <= 2'd0;
      word_index <= '0;
      sleep      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        if (start) state <= RJ;
      end else if (sampleEvt) begin
        if (frameS2) begin
          // A frame always starts a new word; a partial word in flight is dropped
          if (bitCnt != 4'd0) frame_err <= 1'b1;
          shiftReg <= {15'd0, dataS2};
          bitCnt   <= 4'd1;
        end else if (bitCnt != 4'd0) begin
          shiftReg <= nextWord;
          if (bitCnt == 4'd15) begin
            bitCnt     <= 4'd0;
            word       <= nextWord;
            word_valid <= 1'b1;
            word_type  <= curType;
            word_index <= classIdx;
            case (state)
              RJ: begin
                if (classIdx == RJ_LAST) begin
                  state    <= COEFF;
                  classIdx <= '0;
                end else begin
                  classIdx <= classIdx + IDX_W'(1);
                end
              end
              COEFF: begin
                if (classIdx == COEFF_LAST) begin
                  state    <= DATA;
                  classIdx <= '0;
                end else begin
                  classIdx <= classIdx + IDX_W'(1);
                end
              end
              default: begin
                classIdx <= classIdx + IDX_W'(1);
                if (nextWord == 16'd0) begin
                  if (zeroCnt != ZERO_MAX) zeroCnt <= zeroCnt + ZW'(1);
                  sleep <= (zeroCnt >= ZERO_PRE);
                end else begin
                  zeroCnt <= '0;
                  sleep   <= 1'b0;
                end
              end
            endcase
          end else begin
            bitCnt <= bitCnt + 4'd1;
          end
        end
      end
    end
  end

endmodule
